// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sched_pkg
//  Description : Shared types and constants for the dual-issue scheduler:
//                FSM state encoding, load result-source code, counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package sched_pkg;

  // Counter width for the stall / flush performance counters
  localparam int c_cnt_w = 16;

  // ResultSrcE encoding that marks a load sitting in execute
  localparam logic [1:0] c_result_src_load = 2'b01;

  // PAIR: both lanes issue together; SPLIT: lane 1 of the held pair is gone,
  // lane 2 still waiting in decode
  typedef enum logic [0:0] {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } sched_state_e;

  // True when the execute-stage result select denotes a load
  function automatic logic is_load(input logic [1:0] result_src);
    return result_src == c_result_src_load;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_compare.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_compare
//  Description : One source-versus-destination register compare. x0 is
//                hard-wired zero, so a zero source never creates a hazard.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_compare (
  input  logic [4:0] i_src,
  input  logic [4:0] i_dst,
  output logic       o_match
);

  assign o_match = (i_src != 5'd0) && (i_src == i_dst);

endmodule
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dual_issue_scheduler
//  Description : Issue control for a two-lane in-order pipeline. Resolves
//                redirects, load-use stalls and intra-pair dependencies,
//                splitting a dependent pair over two cycles. Control outputs
//                are combinational; stall/flush cycles are counted.
//  Revision    : 1.0  initial release
// ============================================================================
module dual_issue_scheduler
  import sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         Rs1D,
  input  logic [4:0]         Rs2D,
  input  logic [4:0]         Rs4D,
  input  logic [4:0]         Rs5D,
  input  logic [4:0]         RdD1,
  input  logic               RegWriteD1,
  input  logic               MemOpD1,
  input  logic               MemOpD2,
  input  logic [4:0]         RdE1,
  input  logic [4:0]         RdE2,
  input  logic [1:0]         ResultSrcE1,
  input  logic [1:0]         ResultSrcE2,
  input  logic               PCSrcE1,
  input  logic               PCSrcE2,
  output logic               StallF,
  output logic               StallD,
  output logic               FlushD,
  output logic               en1,
  output logic               en2,
  output logic               rst1,
  output logic               rst2,
  output logic               KillE2,
  output logic [c_cnt_w-1:0] StallCount,
  output logic [c_cnt_w-1:0] FlushCount
);

  localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};

  sched_state_e       r_state;
  sched_state_e       w_next_state;
  logic [c_cnt_w-1:0] r_stall_count;
  logic [c_cnt_w-1:0] r_flush_count;

  // Decode sources: index 0/1 are lane 1, index 2/3 are lane 2
  logic [4:0] w_src [4];
  logic [4:0] w_dst [2];
  logic [1:0] w_is_load;
  logic [7:0] w_lu_match;     // [src*2 + execute lane]
  logic [1:0] w_intra_match;  // lane-2 source vs lane-1 destination

  logic w_redirect;
  logic w_load_use;
  logic w_intra;

  logic w_stall_f;
  logic w_stall_d;
  logic w_flush_d;
  logic w_en1;
  logic w_en2;
  logic w_rst1;
  logic w_rst2;

  assign w_src[0] = Rs1D;
  assign w_src[1] = Rs2D;
  assign w_src[2] = Rs4D;
  assign w_src[3] = Rs5D;
  assign w_dst[0] = RdE1;
  assign w_dst[1] = RdE2;

  assign w_is_load[0] = is_load(ResultSrcE1);
  assign w_is_load[1] = is_load(ResultSrcE2);

  // Every decode source against every execute destination
  for (genvar s = 0; s < 4; s++) begin : g_lu_src
    for (genvar d = 0; d < 2; d++) begin : g_lu_dst
      hazard_compare u_cmp (
        .i_src   (w_src[s]),
        .i_dst   (w_dst[d]),
        .o_match (w_lu_match[s*2 + d])
      );
    end
  end

  // Lane-2 sources against the lane-1 destination of the same pair
  for (genvar k = 0; k < 2; k++) begin : g_intra
    hazard_compare u_cmp (
      .i_src   (w_src[2 + k]),
      .i_dst   (RdD1),
      .o_match (w_intra_match[k])
    );
  end

  assign w_redirect = PCSrcE1 | PCSrcE2;

  // Load-use: in SPLIT lane 1 already left decode, so only lane-2 sources count
  always_comb begin
    w_load_use = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 2; d++) begin
        if (w_lu_match[s*2 + d] && w_is_load[d] && ((r_state == ST_PAIR) || (s >= 2)))
          w_load_use = 1'b1;
      end
    end
  end

  assign w_intra = (RegWriteD1 && (|w_intra_match)) || (MemOpD1 && MemOpD2);

  // Priority resolution: reset > redirect > load-use > split completion > intra-pair > normal
  always_comb begin
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_flush_d    = 1'b0;
    w_en1        = 1'b1;
    w_en2        = 1'b1;
    w_rst1       = 1'b0;
    w_rst2       = 1'b0;
    w_next_state = ST_PAIR;
    if (rst) begin
      w_en1     = 1'b0;
      w_en2     = 1'b0;
      w_rst1    = 1'b1;
      w_rst2    = 1'b1;
      w_flush_d = 1'b1;
    end else if (w_redirect) begin
      w_en1     = 1'b0;
      w_en2     = 1'b0;
      w_rst1    = 1'b1;
      w_rst2    = 1'b1;
      w_flush_d = 1'b1;
    end else if (w_load_use) begin
      w_stall_f    = 1'b1;
      w_stall_d    = 1'b1;
      w_en1        = 1'b0;
      w_en2        = 1'b0;
      w_rst1       = 1'b1;
      w_rst2       = 1'b1;
      w_next_state = r_state;
    end else if (r_state == ST_SPLIT) begin
      w_en1  = 1'b0;
      w_rst1 = 1'b1;
    end else if (w_intra) begin
      w_stall_f    = 1'b1;
      w_stall_d    = 1'b1;
      w_en2        = 1'b0;
      w_rst2       = 1'b1;
      w_next_state = ST_SPLIT;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_PAIR;
    else     r_state <= w_next_state;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall_d && (r_stall_count != c_cnt_max)) r_stall_count <= r_stall_count + 1'b1;
      if (w_flush_d && (r_flush_count != c_cnt_max)) r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign StallF     = w_stall_f;
  assign StallD     = w_stall_d;
  assign FlushD     = w_flush_d;
  assign en1        = w_en1;
  assign en2        = w_en2;
  assign rst1       = w_rst1;
  assign rst2       = w_rst2;
  assign KillE2     = PCSrcE1 & ~rst;
  assign StallCount = r_stall_count;
  assign FlushCount = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_issue_scheduler
//  Description : Self-checking bench for dual_issue_scheduler: directed
//                scenarios plus random traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dual_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs4D, Rs5D, RdD1, RdE1, RdE2;
  logic        RegWriteD1, MemOpD1, MemOpD2, PCSrcE1, PCSrcE2;
  logic [1:0]  ResultSrcE1, ResultSrcE2;
  logic        StallF, StallD, FlushD, en1, en2, rst1, rst2, KillE2;
  logic [15:0] StallCount, FlushCount;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  bit          m_split  = 1'b0;
  int unsigned m_stall  = 0;
  int unsigned m_flush  = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs4D        (Rs4D),
    .Rs5D        (Rs5D),
    .RdD1        (RdD1),
    .RegWriteD1  (RegWriteD1),
    .MemOpD1     (MemOpD1),
    .MemOpD2     (MemOpD2),
    .RdE1        (RdE1),
    .RdE2        (RdE2),
    .ResultSrcE1 (ResultSrcE1),
    .ResultSrcE2 (ResultSrcE2),
    .PCSrcE1     (PCSrcE1),
    .PCSrcE2     (PCSrcE2),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .en1         (en1),
    .en2         (en2),
    .rst1        (rst1),
    .rst2        (rst2),
    .KillE2      (KillE2),
    .StallCount  (StallCount),
    .FlushCount  (FlushCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control vector layout: {StallF, StallD, FlushD, en1, en2, rst1, rst2, KillE2}
  task automatic model(output logic [7:0] ctl, output bit nsplit);
    logic [4:0] srcs[$];
    logic [4:0] loads[$];
    bit lu, intra;
    logic k;
    k = PCSrcE1;
    if (rst) begin
      ctl = 8'b0010_0110; nsplit = 1'b0; return;
    end
    if (PCSrcE1 || PCSrcE2) begin
      ctl = {7'b0010_011, k}; nsplit = 1'b0; return;
    end
    if (!m_split) begin srcs.push_back(Rs1D); srcs.push_back(Rs2D); end
    srcs.push_back(Rs4D); srcs.push_back(Rs5D);
    if (ResultSrcE1 == 2'b01) loads.push_back(RdE1);
    if (ResultSrcE2 == 2'b01) loads.push_back(RdE2);
    lu = 1'b0;
    foreach (srcs[i]) foreach (loads[j])
      if (srcs[i] != 0 && srcs[i] == loads[j]) lu = 1'b1;
    if (lu) begin
      ctl = {7'b1100_011, k}; nsplit = m_split; return;
    end
    if (m_split) begin
      ctl = {7'b0000_110, k}; nsplit = 1'b0; return;
    end
    intra = (RegWriteD1 && RdD1 != 0 && (RdD1 == Rs4D || RdD1 == Rs5D)) || (MemOpD1 && MemOpD2);
    if (intra) begin
      ctl = {7'b1101_001, k}; nsplit = 1'b1;
    end else begin
      ctl = {7'b0001_100, k}; nsplit = 1'b0;
    end
  endtask

  // Evaluate current inputs, optionally compare, then advance one clock
  task automatic cycle(input bit chk, output logic [7:0] obs);
    logic [7:0] e;
    bit ns;
    #1;
    model(e, ns);
    obs = {StallF, StallD, FlushD, en1, en2, rst1, rst2, KillE2};
    if (chk) begin
      check("ctl", {24'd0, obs}, {24'd0, e});
      check("stall_cnt", {16'd0, StallCount}, m_stall);
      check("flush_cnt", {16'd0, FlushCount}, m_flush);
    end
    @(posedge clk);
    if (rst) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (e[6] && m_stall < 32'hFFFF) m_stall++;
      if (e[5] && m_flush < 32'hFFFF) m_flush++;
    end
    m_split = ns;
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    Rs1D = 0; Rs2D = 0; Rs4D = 0; Rs5D = 0; RdD1 = 0; RdE1 = 0; RdE2 = 0;
    RegWriteD1 = 0; MemOpD1 = 0; MemOpD2 = 0; PCSrcE1 = 0; PCSrcE2 = 0;
    ResultSrcE1 = 0; ResultSrcE2 = 0;
  endtask

  task automatic rand_inputs();
    rst         = ($urandom_range(0, 31) == 0);
    Rs1D        = 5'($urandom_range(0, 4));
    Rs2D        = 5'($urandom_range(0, 4));
    Rs4D        = 5'($urandom_range(0, 4));
    Rs5D        = 5'($urandom_range(0, 4));
    RdD1        = 5'($urandom_range(0, 4));
    RdE1        = 5'($urandom_range(0, 4));
    RdE2        = 5'($urandom_range(0, 4));
    RegWriteD1  = 1'($urandom_range(0, 1));
    MemOpD1     = ($urandom_range(0, 3) == 0);
    MemOpD2     = ($urandom_range(0, 3) == 0);
    ResultSrcE1 = 2'($urandom_range(0, 3));
    ResultSrcE2 = 2'($urandom_range(0, 3));
    PCSrcE1     = ($urandom_range(0, 9) == 0);
    PCSrcE2     = ($urandom_range(0, 9) == 0);
  endtask

  // Main stimulus sequence
  initial begin
    logic [7:0] obs;
    int unsigned guard;
    clear_inputs();
    rst = 1'b1;
    cycle(1, obs);
    check("reset_ctl", {24'd0, obs}, 32'h26);
    cycle(1, obs);
    rst = 1'b0;
    cycle(1, obs);
    check("reset_counters", {StallCount, FlushCount}, 32'h0000_0000);

    // Independent pair issues together and stays in PAIR
    clear_inputs(); Rs4D = 5; RdD1 = 3; RegWriteD1 = 1;
    cycle(1, obs); check("indep_pair", {24'd0, obs}, 32'h18);
    cycle(1, obs); check("indep_pair_again", {24'd0, obs}, 32'h18);

    // Intra-pair RAW splits the pair over two cycles
    clear_inputs(); RdD1 = 7; RegWriteD1 = 1; Rs5D = 7;
    cycle(1, obs); check("split_c0", {24'd0, obs}, 32'hD2);
    cycle(1, obs); check("split_c1", {24'd0, obs}, 32'h0C);
    clear_inputs();
    cycle(1, obs); check("split_back_pair", {24'd0, obs}, 32'h18);

    // x0 never matches, even for a lane-1 write to x0
    clear_inputs(); RdD1 = 0; RegWriteD1 = 1; Rs4D = 0; ResultSrcE1 = 2'b01; RdE1 = 0;
    cycle(1, obs); check("x0_no_hazard", {24'd0, obs}, 32'h18);

    // Both lanes touching memory also splits
    clear_inputs(); MemOpD1 = 1; MemOpD2 = 1;
    cycle(1, obs); check("memop_split", {24'd0, obs}, 32'hD2);
    clear_inputs();
    cycle(1, obs);

    // Load-use on lane-2 load: single bubble, counter steps once
    clear_inputs(); ResultSrcE2 = 2'b01; RdE2 = 9; Rs1D = 9;
    guard = {16'd0, StallCount};
    cycle(1, obs); check("loaduse_bubble", {24'd0, obs}, 32'hC6);
    clear_inputs();
    cycle(1, obs); check("loaduse_cnt", {16'd0, StallCount}, guard + 1);

    // Load-use beats intra-pair, then redirect while in SPLIT
    clear_inputs(); ResultSrcE1 = 2'b01; RdE1 = 4; Rs2D = 4; RdD1 = 6; RegWriteD1 = 1; Rs4D = 6;
    cycle(1, obs); check("lu_over_intra", {24'd0, obs}, 32'hC6);
    ResultSrcE1 = 2'b00;
    cycle(1, obs); check("intra_after_lu", {24'd0, obs}, 32'hD2);
    PCSrcE1 = 1;
    cycle(1, obs); check("redirect_in_split", {24'd0, obs}, 32'h27);
    clear_inputs();
    cycle(1, obs); check("redirect_to_pair", {24'd0, obs}, 32'h18);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle(1, obs);
    end

    // Drive FlushCount to saturation with lane-2 redirects
    clear_inputs(); PCSrcE2 = 1;
    guard = 0;
    while (m_flush < 32'hFFFF && guard < 70000) begin
      cycle(0, obs);
      guard++;
    end
    check("flush_reach_max_bound", {31'd0, (guard >= 70000)}, 32'd0);
    cycle(1, obs);
    cycle(1, obs);
    check("flush_saturated", {16'd0, FlushCount}, 32'hFFFF);

    // Reset in the middle of a split returns to PAIR with counters cleared
    clear_inputs(); RdD1 = 2; RegWriteD1 = 1; Rs4D = 2;
    cycle(1, obs); check("presplit", {24'd0, obs}, 32'hD2);
    rst = 1'b1;
    cycle(1, obs); check("reset_mid_split", {24'd0, obs}, 32'h26);
    clear_inputs();
    cycle(1, obs); check("after_reset_pair", {24'd0, obs}, 32'h18);
    check("after_reset_counters", {StallCount, FlushCount}, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
